// File: rtl/bfp_normalizer_if.sv
// Clock/reset bundle and valid/ready/last handshake bundle used by bfp_normalizer.
interface clk_rstn_intrf;
  logic clk;
  logic rstn;

  modport slave (input clk, input rstn);
endinterface

interface axi_ctr_intrf;
  logic tvalid;
  logic tready;
  logic tlast;

  modport s_axis (input tvalid, input tlast, output tready);
  modport m_axis (output tvalid, output tlast, input tready);
endinterface

// File: rtl/bfp_normalizer.sv
// Block-floating-point normalizer: buffers a frame of samples, picks one shift code that is
// safe for every sample in the frame, then replays the frame with that common shift applied.
module bfp_normalizer #(
  parameter int unsigned width     = 8,
  parameter int unsigned shamtbits = 4,
  parameter int unsigned frame_len = 16
) (
  clk_rstn_intrf.slave        clk_rstn_i,
  axi_ctr_intrf.s_axis        s_axis,
  axi_ctr_intrf.m_axis        m_axis,
  input  logic [width-1:0]     data_i,
  input  logic [shamtbits-1:0] shamt_i,
  output logic [width-1:0]     data_o,
  output logic [shamtbits-1:0] blk_shamt_o
);

  localparam int unsigned AddrW = $clog2(frame_len);
  localparam int unsigned LW    = shamtbits - 1;

  if (!((width == 8 && shamtbits == 4) || (width == 16 && shamtbits == 5))) begin : g_bad_width
    $error("bfp_normalizer: (width, shamtbits) must be (8,4) or (16,5)");
  end
  if (frame_len < 2 || (frame_len & (frame_len - 1)) != 0) begin : g_bad_len
    $error("bfp_normalizer: frame_len must be a power of two >= 2");
  end

  typedef enum logic [0:0] {StCollect, StEmit} state_e;

  state_e               state_q, state_d;
  logic [AddrW-1:0]     wr_cnt_q, wr_cnt_d;
  logic [AddrW-1:0]     rd_cnt_q, rd_cnt_d;
  logic [AddrW-1:0]     last_idx_q, last_idx_d;
  logic                 any_r_q, any_r_d;
  logic [LW-1:0]        min_l_q, min_l_d;
  logic [shamtbits-1:0] blk_q, blk_d;
  logic                 s_tready_q, s_tready_d;
  logic                 m_tvalid_q, m_tvalid_d;
  logic                 m_tlast_q, m_tlast_d;
  logic [width-1:0]     data_q, data_d;
  logic [width-1:0]     buf_q [frame_len];

  logic             in_fire, out_fire, first, frame_close;
  logic             in_r, any_r_new;
  logic [LW-1:0]    in_l, min_l_new;
  logic [AddrW-1:0] rd_nxt;

  function automatic logic [width-1:0] apply_shift(input logic [width-1:0]     s,
                                                   input logic [shamtbits-1:0] c);
    if (c[LW]) begin
      return {s[width-1], s[width-1:1]};
    end
    return s << c[LW-1:0];
  endfunction

  assign in_fire     = s_axis.tvalid & s_tready_q;
  assign out_fire    = m_tvalid_q & m_axis.tready;
  assign first       = (wr_cnt_q == '0);
  assign frame_close = in_fire & (s_axis.tlast | (wr_cnt_q == AddrW'(frame_len - 1)));
  assign in_r        = shamt_i[LW];
  assign in_l        = shamt_i[LW-1:0];
  assign rd_nxt      = rd_cnt_q + AddrW'(1);

  // Frame statistics restart from the incoming sample at the head of each frame.
  assign any_r_new = first ? in_r : (any_r_q | in_r);
  assign min_l_new = (first || in_l < min_l_q) ? in_l : min_l_q;

  // State register
  always_ff @(posedge clk_rstn_i.clk or negedge clk_rstn_i.rstn) begin
    if (!clk_rstn_i.rstn) begin
      state_q <= StCollect;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StCollect: if (frame_close) state_d = StEmit;
      StEmit:    if (out_fire && m_tlast_q) state_d = StCollect;
      default:   state_d = StCollect;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    last_idx_d = last_idx_q;
    any_r_d    = any_r_q;
    min_l_d    = min_l_q;
    blk_d      = blk_q;
    m_tlast_d  = m_tlast_q;
    data_d     = data_q;

    if (in_fire) begin
      wr_cnt_d = wr_cnt_q + AddrW'(1);
      any_r_d  = any_r_new;
      min_l_d  = min_l_new;
    end

    if (frame_close) begin
      wr_cnt_d   = '0;
      rd_cnt_d   = '0;
      last_idx_d = wr_cnt_q;
      blk_d      = any_r_new ? {1'b1, {LW{1'b0}}} : {1'b0, min_l_new};
      // Sample 0 may be arriving this very cycle (one-sample frame), so bypass the buffer.
      data_d     = apply_shift(first ? data_i : buf_q[0], blk_d);
      m_tlast_d  = first;
    end

    if (out_fire) begin
      if (m_tlast_q) begin
        rd_cnt_d  = '0;
        m_tlast_d = 1'b0;
      end else begin
        rd_cnt_d  = rd_nxt;
        data_d    = apply_shift(buf_q[rd_nxt], blk_q);
        m_tlast_d = (rd_nxt == last_idx_q);
      end
    end

    s_tready_d = (state_d == StCollect);
    m_tvalid_d = (state_d == StEmit);
  end

  always_ff @(posedge clk_rstn_i.clk or negedge clk_rstn_i.rstn) begin
    if (!clk_rstn_i.rstn) begin
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      last_idx_q <= '0;
      any_r_q    <= 1'b0;
      min_l_q    <= '1;
      blk_q      <= '0;
      s_tready_q <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      data_q     <= '0;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      last_idx_q <= last_idx_d;
      any_r_q    <= any_r_d;
      min_l_q    <= min_l_d;
      blk_q      <= blk_d;
      s_tready_q <= s_tready_d;
      m_tvalid_q <= m_tvalid_d;
      m_tlast_q  <= m_tlast_d;
      data_q     <= data_d;
    end
  end

  // Sample storage needs no reset; a discarded frame is simply overwritten.
  always_ff @(posedge clk_rstn_i.clk) begin
    if (in_fire) begin
      buf_q[wr_cnt_q] <= data_i;
    end
  end

  assign s_axis.tready = s_tready_q;
  assign m_axis.tvalid = m_tvalid_q;
  assign m_axis.tlast  = m_tlast_q;
  assign data_o        = data_q;
  assign blk_shamt_o   = blk_q;

endmodule

// File: tb/tb_bfp_normalizer.sv
// Scoreboard bench for bfp_normalizer: a reference model queues expected outputs per frame.
module tb_bfp_normalizer;
  localparam int W  = 8;
  localparam int SB = 4;
  localparam int FL = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  clk_rstn_intrf cr_if ();
  axi_ctr_intrf  s_if ();
  axi_ctr_intrf  m_if ();
  assign cr_if.clk = clk;

  logic [W-1:0]  data_i, data_o;
  logic [SB-1:0] shamt_i, blk_o;

  bfp_normalizer #(.width(W), .shamtbits(SB), .frame_len(FL)) dut (
    .clk_rstn_i  (cr_if),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .data_i      (data_i),
    .shamt_i     (shamt_i),
    .data_o      (data_o),
    .blk_shamt_o (blk_o)
  );

  typedef struct packed {
    logic [W-1:0]  d;
    logic          last;
    logic [SB-1:0] blk;
  } exp_t;

  exp_t          exp_q[$];
  logic [W-1:0]  fd[$];
  logic [SB-1:0] fc[$];
  int tests_run, tests_failed;

  function automatic logic [W-1:0] model_shift(input logic [W-1:0] d, input logic [SB-1:0] c);
    int v;
    v = int'($signed(d));
    if (c[SB-1]) v = v >>> 1;
    else v = v * (1 << c[SB-2:0]);
    return v[W-1:0];
  endfunction

  task automatic add(input logic [W-1:0] d, input logic r, input logic [SB-2:0] l);
    fd.push_back(d);
    fc.push_back({r, l});
  endtask

  task automatic model_frame();
    logic any_r;
    logic [SB-2:0] min_l;
    logic [SB-1:0] blk;
    exp_t e;
    any_r = 1'b0;
    min_l = '1;
    foreach (fc[i]) begin
      any_r = any_r | fc[i][SB-1];
      if (fc[i][SB-2:0] < min_l) min_l = fc[i][SB-2:0];
    end
    blk = any_r ? 4'b1000 : {1'b0, min_l};
    foreach (fd[i]) begin
      e.d    = model_shift(fd[i], blk);
      e.last = (i == fd.size() - 1);
      e.blk  = blk;
      exp_q.push_back(e);
    end
  endtask

  // Drives the queued frame; called and returns on a negedge.
  task automatic send_frame(input bit use_last, input string name);
    int guard;
    model_frame();
    foreach (fd[i]) begin
      s_if.tvalid = 1'b1;
      s_if.tlast  = use_last && (i == fd.size() - 1);
      data_i      = fd[i];
      shamt_i     = fc[i];
      guard = 0;
      while (!s_if.tready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) begin
        tests_run++;
        tests_failed++;
        $display("FAIL %s input_timeout got tready=%b want 1", name, s_if.tready);
      end
      @(negedge clk);
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    tests_run++;
    if (m_if.tvalid !== 1'b1 || s_if.tready !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s latency got tvalid=%b tready=%b want 1 0", name, m_if.tvalid,
               s_if.tready);
    end
    fd.delete();
    fc.delete();
  endtask

  // Consumes up to max_out outputs, optionally stalling before output stall_at.
  task automatic recv(input string name, input int max_out, input int stall_at, input bit rnd);
    int cnt, guard;
    exp_t e;
    logic [W-1:0] sd;
    logic sl;
    logic [SB-1:0] sb;
    cnt = 0;
    guard = 0;
    while (exp_q.size() > 0 && cnt < max_out && guard < 400) begin
      if (cnt == stall_at) begin
        m_if.tready = 1'b0;
        sd = data_o; sl = m_if.tlast; sb = blk_o;
        repeat (3) begin
          @(negedge clk);
          tests_run++;
          if (data_o !== sd || m_if.tlast !== sl || blk_o !== sb || m_if.tvalid !== 1'b1 ||
              s_if.tready !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s stall_hold got d=%h l=%b b=%b v=%b rdy=%b want d=%h l=%b b=%b v=1 rdy=0",
                     name, data_o, m_if.tlast, blk_o, m_if.tvalid, s_if.tready, sd, sl, sb);
          end
        end
        stall_at = -1;
      end
      m_if.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_if.tvalid && m_if.tready) begin
        e = exp_q.pop_front();
        tests_run++;
        if (data_o !== e.d || m_if.tlast !== e.last || blk_o !== e.blk) begin
          tests_failed++;
          $display("FAIL %s out[%0d] got d=%h l=%b b=%b want d=%h l=%b b=%b", name, cnt,
                   data_o, m_if.tlast, blk_o, e.d, e.last, e.blk);
        end
        cnt++;
      end
      @(negedge clk);
      guard++;
    end
    m_if.tready = 1'b1;
    if (guard >= 400) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s output_timeout got %0d outputs want %0d more", name, cnt, exp_q.size());
    end
    if (exp_q.size() == 0) begin
      tests_run++;
      if (m_if.tvalid !== 1'b0 || s_if.tready !== 1'b1) begin
        tests_failed++;
        $display("FAIL %s back_to_collect got tvalid=%b tready=%b want 0 1", name, m_if.tvalid,
                 s_if.tready);
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    tests_run++;
    if (s_if.tready !== 1'b0 || m_if.tvalid !== 1'b0 || m_if.tlast !== 1'b0 ||
        data_o !== '0 || blk_o !== '0) begin
      tests_failed++;
      $display("FAIL %s reset_outputs got rdy=%b v=%b l=%b d=%h b=%b want all 0", name,
               s_if.tready, m_if.tvalid, m_if.tlast, data_o, blk_o);
    end
  endtask

  task automatic test_reset();
    cr_if.rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    cr_if.rstn = 1'b1;
    #1;
    tests_run++;
    if (s_if.tready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset tready_early got %b want 0", s_if.tready);
    end
    @(negedge clk);
    tests_run++;
    if (s_if.tready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset tready_rise got %b want 1", s_if.tready);
    end
  endtask

  task automatic test_left_shift();
    add(8'h10, 1'b0, 3'd2); add(8'h08, 1'b0, 3'd3); add(8'h04, 1'b0, 3'd4);
    send_frame(1'b1, "left");
    recv("left", 100, -1, 1'b0);
  endtask

  task automatic test_right_shift();
    add(8'h30, 1'b1, 3'd0); add(8'h02, 1'b0, 3'd5);
    send_frame(1'b1, "right");
    recv("right", 100, -1, 1'b0);
  endtask

  task automatic test_sign();
    add(8'hF0, 1'b0, 3'd2); add(8'hFF, 1'b0, 3'd6);
    send_frame(1'b1, "sign");
    recv("sign", 100, -1, 1'b0);
  endtask

  task automatic test_frame_len();
    for (int i = 0; i < FL; i++) add(8'(i + 1), 1'b0, 3'(i % 8));
    send_frame(1'b0, "full_no_last");
    recv("full_no_last", 100, -1, 1'b0);
    for (int i = 0; i < FL; i++) add(8'(i * 3), 1'b0, 3'd1);
    send_frame(1'b1, "full_with_last");
    recv("full_with_last", 100, -1, 1'b0);
    add(8'h05, 1'b0, 3'd3);
    send_frame(1'b1, "single");
    recv("single", 100, -1, 1'b0);
  endtask

  task automatic test_stall();
    add(8'h11, 1'b0, 3'd1); add(8'h22, 1'b0, 3'd2); add(8'h33, 1'b0, 3'd1);
    add(8'h44, 1'b0, 3'd3);
    send_frame(1'b1, "stall");
    recv("stall", 100, 1, 1'b0);
  endtask

  task automatic test_reset_mid_emit();
    for (int i = 0; i < 5; i++) add(8'(8'h21 + i), 1'b0, 3'd1);
    send_frame(1'b1, "rst_mid");
    recv("rst_mid", 2, -1, 1'b0);
    #2 cr_if.rstn = 1'b0;
    #1 check_reset_outputs("rst_mid");
    exp_q.delete();
    @(negedge clk);
    cr_if.rstn = 1'b1;
    @(negedge clk);
    add(8'h07, 1'b0, 3'd4); add(8'h81, 1'b1, 3'd0); add(8'h13, 1'b0, 3'd2);
    send_frame(1'b1, "after_rst");
    recv("after_rst", 100, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    int n;
    bit use_last;
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(1, FL);
      use_last = (n < FL) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++)
        add(8'($urandom), 1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)));
      send_frame(use_last, "random");
      recv("random", 100, -1, 1'b1);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cr_if.rstn   = 1'b0;
    s_if.tvalid  = 1'b0;
    s_if.tlast   = 1'b0;
    m_if.tready  = 1'b1;
    data_i       = '0;
    shamt_i      = '0;
    @(negedge clk);
    test_reset();
    test_left_shift();
    test_right_shift();
    test_sign();
    test_frame_len();
    test_stall();
    test_reset_mid_emit();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/bfp_normalizer.md
BFP_NORMALIZER -- requirements
Module: bfp_normalizer

Interface
REQ-001 SHALL have parameter width, default 8, meaning sample width in bits.
REQ-002 SHALL have parameter shamtbits, default 4, meaning shift-code width: 1 right-shift flag bit plus left-shift field.
REQ-003 SHALL have parameter frame_len, default 16, meaning maximum samples per frame; power of two, >= 2.
REQ-004 SHALL fail elaboration via $error unless (width,shamtbits) is (8,4) or (16,5).
REQ-005 SHALL have port clk_rstn_i, input, clk_rstn_intrf.slave: single clock clk; reset rstn, asynchronous, active-low.
REQ-006 SHALL have port s_axis, input, axi_ctr_intrf.s_axis: tvalid/tready/tlast for upstream samples.
REQ-007 SHALL have port m_axis, output, axi_ctr_intrf.m_axis: tvalid/tready/tlast for normalized samples.
REQ-008 SHALL have port data_i, input, width: signed sample from the upstream shift-amount stage.
REQ-009 SHALL have port shamt_i, input, shamtbits: per-sample code {r, l}; r=1 means right shift 1 is needed, else l is the safe left shift.
REQ-010 SHALL have port data_o, output, width: signed normalized sample.
REQ-011 SHALL have port blk_shamt_o, output, shamtbits: frame-common code applied, same {r, l} encoding.

Function
REQ-012 SHALL implement FSM with states COLLECT and EMIT; reset state COLLECT.
REQ-013 COLLECT: s_axis.tready=1, m_axis.tvalid=0; sample accepted on tvalid&&tready, written to buffer[wr_cnt], wr_cnt incremented.
REQ-014 Per frame SHALL track any_r = OR of accepted r bits and min_l = minimum of accepted l fields; both initialized on the first sample of each frame.
REQ-015 Frame SHALL close on an accepted sample with tlast=1, or on the frame_len-th accepted sample, whichever comes first; frame length n = samples accepted (1..frame_len).
REQ-016 On close SHALL latch blk_shamt_o = {1, 0} if any_r, else {0, min_l}, and enter EMIT the next cycle; s_axis.tready=0 throughout EMIT.
REQ-017 EMIT: m_axis.tvalid=1, data_o = buffer[rd_cnt] arithmetically shifted right 1 if r flag, else shifted left by l; result truncated to width bits.
REQ-018 An output transfer occurs on m_axis.tvalid&&m_axis.tready; rd_cnt then increments.
REQ-019 data_o, m_axis.tlast and blk_shamt_o SHALL stay stable while tvalid=1 and tready=0.
REQ-020 m_axis.tlast SHALL be 1 only on sample n-1 of the frame.
REQ-021 After the tlast transfer SHALL return to COLLECT the next cycle with wr_cnt=rd_cnt=0; blk_shamt_o holds until the next frame closes.
REQ-022 Latency: first output tvalid SHALL be 1 cycle after the closing input transfer; with tready held high, one output per cycle.
REQ-023 Samples are not accepted while in EMIT; input presented then is held by upstream (tready=0).
REQ-024 A frame of exactly frame_len samples with tlast=1 on the last one SHALL close once; no empty frame follows.

Reset
REQ-025 rstn low SHALL asynchronously force COLLECT, counters 0, any_r=0, min_l=all-ones, s_axis.tready=0, m_axis.tvalid=0, m_axis.tlast=0, data_o=0, blk_shamt_o=0.
REQ-026 s_axis.tready SHALL rise on the first clock edge after rstn deasserts.
REQ-027 Reset mid-frame (either state) SHALL discard the partial frame; the buffer contents need not be cleared.

Verification
REQ-028 width=8: inputs 0x10/l=2, 0x08/l=3, 0x04/l=4 with tlast on the third -> outputs 0x40, 0x20, 0x10, tlast on 0x10, blk_shamt_o=4'b0010.
REQ-029 Inputs 0x30/{1,0} and 0x02/l=5 with tlast -> outputs 0x18, 0x01, blk_shamt_o=4'b1000.
REQ-030 Input 0xF0/l=2 and 0xFF/l=6 with tlast -> outputs 0xC0, 0xFC; checks sign preservation.
REQ-031 16 samples with no tlast -> frame closes after sample 16, output tlast on the 16th; a single sample with tlast -> 1-sample frame with tlast.
REQ-032 During EMIT hold m_axis.tready=0 for 3 cycles -> data_o, tlast and blk_shamt_o unchanged; s_axis.tready stays 0; no sample lost or duplicated.
REQ-033 Assert rstn low during EMIT after 2 of 5 outputs -> all outputs 0 immediately; the next frame is processed correctly with no residue.
